// File: rtl/ahb_lite_dmem_slave.sv
// ahb_lite_dmem_slave
//   AHB-Lite data-memory slave. It holds DEPTH_WORDS 32-bit words, inserts
//   WAIT_CYCLES wait states into each OKAY data phase, and answers illegal
//   transfers with the two-cycle ERROR response.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   HSEL, HADDR,      address-phase inputs, latched when a transfer is accepted
//   HTRANS, HWRITE,
//   HSIZE
//   HWDATA            write data, sampled in the completing data-phase cycle
//   HREADY            bus-wide ready; no transfer is accepted while it is low
//   HRDATA            read data, non-zero only in a completing read cycle
//   HREADYOUT, HRESP  slave ready and response (0 OKAY, 1 ERROR)
//
// state  | meaning
// S_IDLE | ready; completes a pending OKAY data phase when pend_q is set
// S_WAIT | wait states for an OKAY transfer, counting cnt_q down to zero
// S_ERR1 | first ERROR cycle (HREADYOUT low)
// S_ERR2 | second ERROR cycle (HREADYOUT high); a new transfer can be accepted
module ahb_lite_dmem_slave #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             write_q, write_d;
  logic [3:0]       be_q, be_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [3:0] be_new;
  logic       addr_err;
  logic       rdy_c;
  logic       resp_c;
  logic       complete;
  logic       mem_we;

  // Only HTRANS[1] separates active transfers from IDLE/BUSY.
  logic unused_htrans;
  assign unused_htrans = HTRANS[0];

  // Address-phase decode: byte enables and legality of the offered transfer.
  always_comb begin
    be_new   = 4'b0000;
    addr_err = 1'b0;
    case (HSIZE)
      3'd0: be_new = 4'b0001 << HADDR[1:0];
      3'd1: begin
        be_new   = HADDR[1] ? 4'b1100 : 4'b0011;
        addr_err = HADDR[0];
      end
      3'd2: begin
        be_new   = 4'b1111;
        addr_err = (HADDR[1:0] != 2'b00);
      end
      default: addr_err = 1'b1;
    endcase
    if (32'(HADDR[ADDR_W-1:2]) >= DEPTH_WORDS) addr_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    write_d = write_q;
    be_d    = be_q;
    idx_d   = idx_q;
    rdy_c   = 1'b1;
    resp_c  = 1'b0;

    case (state_q)
      S_WAIT: begin
        rdy_c = 1'b0;
        cnt_d = cnt_q - 4'd1;
        // The last wait cycle hands over to the completion cycle in S_IDLE.
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          pend_d  = 1'b1;
        end
      end
      S_ERR1: begin
        rdy_c   = 1'b0;
        resp_c  = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: resp_c = 1'b1;
      default: ;
    endcase

    // Any ready cycle ends the current data phase and may accept the next one.
    if (rdy_c) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      if (HSEL && HTRANS[1] && HREADY) begin
        write_d = HWRITE;
        be_d    = be_new;
        idx_d   = HADDR[IDX_W+1:2];
        if (addr_err) begin
          state_d = S_ERR1;
          cnt_d   = 4'd0;
        end else if (WAIT_CYCLES > 0) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end else begin
          pend_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      be_q    <= 4'b0000;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      write_q <= write_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
    end
  end

  assign complete  = (state_q == S_IDLE) && pend_q;
  // A reset landing on the completing edge abandons the write as well.
  assign mem_we    = complete && write_q && !RST;
  assign HREADYOUT = rdy_c;
  assign HRESP     = resp_c;
  assign HRDATA    = (complete && !write_q) ? mem[idx_q] : 32'h0;

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_lite_dmem_slave.md
AHB_LITE_DMEM_SLAVE -- requirements
Module: ahb_lite_dmem_slave

Interface
REQ-001 Parameter ADDR_W, 16, byte-address width decoded by the slave.
REQ-002 Parameter DEPTH_WORDS, 1024, number of 32-bit storage words.
REQ-003 Parameter WAIT_CYCLES, 1, wait states per OKAY data phase (0..15).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 HSEL  in  1  slave select.
REQ-007 HADDR  in  ADDR_W  byte address, address phase.
REQ-008 HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-009 HWRITE  in  1  1 write, 0 read.
REQ-010 HSIZE  in  3  0 byte, 1 half, 2 word; others illegal.
REQ-011 HWDATA  in  32  write data, data phase.
REQ-012 HREADY  in  1  bus-wide ready (previous transfer complete).
REQ-013 HRDATA  out  32  read data, full aligned word.
REQ-014 HREADYOUT  out  1  slave ready.
REQ-015 HRESP  out  1  0 OKAY, 1 ERROR.

Function
REQ-016 Transfer SHALL be accepted on a rising edge where HSEL=1, HTRANS[1]=1 and HREADY=1; HADDR, HWRITE, HSIZE SHALL be latched then.
REQ-017 HSEL=1 with IDLE/BUSY, or HSEL=0, SHALL cause no access and a zero-wait OKAY data phase.
REQ-018 Accepted transfer SHALL be ERROR if HSIZE>2, half with HADDR[0]=1, word with HADDR[1:0]!=0, or HADDR[ADDR_W-1:2]>=DEPTH_WORDS.
REQ-019 States: IDLE, WAIT, ERR1, ERR2.
REQ-020 IDLE: HREADYOUT=1, HRESP=0; accepted OKAY transfer -> WAIT if WAIT_CYCLES>0 else stays IDLE with data phase completing next cycle; accepted ERROR transfer -> ERR1.
REQ-021 WAIT: counter loaded with WAIT_CYCLES on acceptance, decremented each cycle; HREADYOUT=0 while counter>0; on 0 -> IDLE-phase completion cycle with HREADYOUT=1.
REQ-022 ERR1: HREADYOUT=0, HRESP=1, one cycle, -> ERR2.
REQ-023 ERR2: HREADYOUT=1, HRESP=1, one cycle; new transfer acceptable here per REQ-016; -> IDLE or next transfer's state.
REQ-024 Completing data-phase cycle (HREADYOUT=1, OKAY) read: HRDATA = mem[latched word index]; all other cycles HRDATA=0.
REQ-025 Completing data-phase cycle write: HWDATA byte lanes written at clock edge; byte lane HADDR[1:0], half lanes {HADDR[1],0}+1..+0, word all four; other bytes unchanged.
REQ-026 ERROR transfers SHALL never modify memory; HRDATA=0.
REQ-027 New transfer accepted in completing cycle SHALL start its own data phase next cycle (back-to-back, no bubble).
REQ-028 Read accepted in a write's completing cycle to same word SHALL return the newly written data.
REQ-029 HREADY=0 in an idle-slave cycle (other slave stalling) SHALL block acceptance; state unchanged.
REQ-030 Single outstanding transfer; latency per OKAY transfer = 1+WAIT_CYCLES cycles after acceptance.

Reset
REQ-031 RST=1 SHALL force IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0 at next edge.
REQ-032 RST during WAIT/ERR1/ERR2 SHALL abandon the transfer; pending write SHALL NOT occur.
REQ-033 Memory contents SHALL NOT be reset.

Verification
REQ-034 WAIT_CYCLES=1: word write 0xDEADBEEF @0x10, then word read @0x10 -> HREADYOUT low 1 cycle each, HRDATA=0xDEADBEEF, HRESP=0.
REQ-035 Word 0x11223344 @0x20, byte write 0xAA @0x21, half write 0x5566 @0x22, read @0x20 -> 0x5566AA44.
REQ-036 Half read @0x03 -> ERR1 (HREADYOUT=0,HRESP=1), ERR2 (HREADYOUT=1,HRESP=1); memory unchanged; HSIZE=3 and address >= DEPTH_WORDS*4 same response.
REQ-037 WAIT_CYCLES=0: NONSEQ write @0x40 then SEQ read @0x40 on consecutive cycles -> no stall, read returns written word next cycle.
REQ-038 RST asserted in WAIT of write 0x12345678 @0x30 -> HREADYOUT=1, HRESP=0 after edge; later read @0x30 returns prior contents.
REQ-039 HREADY=0 with HSEL=1, NONSEQ -> no acceptance, no stall, no memory change.
